// File: rtl/kernel_dma_shell.sv
// kernel_dma_shell: host-to-kernel DMA shell for an HLS accelerator.
// Flow: burst-read host words into an on-chip buffer, pulse ap_start, serve the
// kernel's two buffer ports until ap_done, then write a window of the buffer
// back to the host, pulse done and report the job's cycle count.
// Optional build macro: KERNEL_TIMEOUT_EN adds a RUN-state watchdog that sets
// error and skips write-back after TIMEOUT_CYCLES cycles without ap_done.
// Host handshake: a read word is taken on a cycle where read_enable and
// read_ready are both high; a write word is taken on a cycle where write_enable
// and write_ready are both high. read_addr/read_data and write_addr/write_data
// are held stable until their word is taken.
module kernel_dma_shell #(
    parameter int DATA_WID       = 32,
    parameter int ADDR_WID       = 13,
    parameter int HOST_AW        = 64,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [HOST_AW-1:0]  read_base,
    input  logic [HOST_AW-1:0]  write_base,
    input  logic [HOST_AW-1:0]  stride,
    input  logic [HOST_AW-1:0]  num_read,
    input  logic [HOST_AW-1:0]  num_write,
    input  logic [ADDR_WID-1:0] write_offset,
    input  logic                read_ready,
    input  logic [DATA_WID-1:0] read_data,
    input  logic                write_ready,
    output logic                read_enable,
    output logic [HOST_AW-1:0]  read_addr,
    output logic [HOST_AW-1:0]  read_size_output,
    output logic                finish_read,
    output logic                write_enable,
    output logic [HOST_AW-1:0]  write_addr,
    output logic [HOST_AW-1:0]  write_size,
    output logic [DATA_WID-1:0] write_data,
    output logic                finish_write,
    output logic                done,
    output logic                busy,
    output logic                error,
    output logic [HOST_AW-1:0]  cycles,
    output logic                ap_start,
    input  logic                ap_done,
    input  logic [ADDR_WID-1:0] k_addr0,
    input  logic [ADDR_WID-1:0] k_addr1,
    input  logic                k_ce0,
    input  logic                k_ce1,
    input  logic                k_we0,
    input  logic                k_we1,
    input  logic [DATA_WID-1:0] k_d0,
    input  logic [DATA_WID-1:0] k_d1,
    output logic [DATA_WID-1:0] k_q0,
    output logic [DATA_WID-1:0] k_q1
);

    localparam int                  DEPTH   = 1 << ADDR_WID;
    localparam logic [HOST_AW-1:0]  DEPTH_H = HOST_AW'(DEPTH);
    localparam logic [HOST_AW-1:0]  ONE_H   = HOST_AW'(1);
    localparam logic [ADDR_WID-1:0] ONE_A   = ADDR_WID'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_KSTART, S_RUN, S_WPREP, S_WRITE, S_FIN
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WID-1:0] mem [DEPTH];

    logic [HOST_AW-1:0]  write_base_q;
    logic [HOST_AW-1:0]  stride_q;
    logic [ADDR_WID-1:0] woff_q;
    logic [HOST_AW-1:0]  rd_len;
    logic [HOST_AW-1:0]  wr_len;
    logic [HOST_AW-1:0]  rcnt;
    logic [HOST_AW-1:0]  wcnt;
    logic [ADDR_WID-1:0] widx;
    logic [ADDR_WID-1:0] widx_next;
    logic [HOST_AW-1:0]  cnt;
    logic [HOST_AW-1:0]  num_read_clamp;
    logic [HOST_AW-1:0]  num_write_clamp;
    logic                rd_last;
    logic                wr_last;
    logic                timeout_hit;

    // Buffer never holds more than DEPTH words, so longer requests are clamped.
    assign num_read_clamp  = (num_read  > DEPTH_H) ? DEPTH_H : num_read;
    assign num_write_clamp = (num_write > DEPTH_H) ? DEPTH_H : num_write;
    assign rd_last         = (rcnt == rd_len - ONE_H);
    assign wr_last         = (wcnt == wr_len - ONE_H);
    assign widx_next       = widx + ONE_A;

    assign read_size_output = stride_q;
    assign write_size       = stride_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and state-decoded strobes.
    always_comb begin
        state_nxt    = state;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        ap_start     = 1'b0;
        done         = 1'b0;
        busy         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (num_read_clamp == '0) ? S_KSTART : S_READ;
            end
            S_READ: begin
                read_enable = 1'b1;
                busy        = 1'b1;
                if (read_ready && rd_last) state_nxt = S_KSTART;
            end
            S_KSTART: begin
                ap_start  = 1'b1;
                busy      = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (ap_done)          state_nxt = S_WPREP;
                else if (timeout_hit) state_nxt = S_FIN;
            end
            S_WPREP: begin
                busy      = 1'b1;
                state_nxt = (wr_len == '0) ? S_FIN : S_WRITE;
            end
            S_WRITE: begin
                write_enable = 1'b1;
                busy         = 1'b1;
                if (write_ready && wr_last) state_nxt = S_FIN;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Job parameters, host address/count sequencing, acknowledges and cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_base_q <= '0;
            stride_q     <= '0;
            woff_q       <= '0;
            rd_len       <= '0;
            wr_len       <= '0;
            rcnt         <= '0;
            wcnt         <= '0;
            widx         <= '0;
            read_addr    <= '0;
            write_addr   <= '0;
            write_data   <= '0;
            finish_read  <= 1'b0;
            finish_write <= 1'b0;
            cnt          <= '0;
            cycles       <= '0;
        end else begin
            finish_read  <= 1'b0;
            finish_write <= 1'b0;
            if (busy && cnt != '1) cnt <= cnt + ONE_H;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        write_base_q <= write_base;
                        stride_q     <= stride;
                        woff_q       <= write_offset;
                        rd_len       <= num_read_clamp;
                        wr_len       <= num_write_clamp;
                        read_addr    <= read_base;
                        rcnt         <= '0;
                        cnt          <= '0;
                    end
                end
                S_READ: begin
                    if (read_ready && !rd_last) begin
                        rcnt        <= rcnt + ONE_H;
                        read_addr   <= read_addr + stride_q;
                        finish_read <= 1'b1;
                    end
                end
                S_WPREP: begin
                    write_addr <= write_base_q;
                    widx       <= woff_q;
                    wcnt       <= '0;
                    write_data <= mem[woff_q];
                end
                S_WRITE: begin
                    // Next word is fetched on the handshake so it is presented
                    // the following cycle without a bubble.
                    if (write_ready && !wr_last) begin
                        wcnt         <= wcnt + ONE_H;
                        widx         <= widx_next;
                        write_data   <= mem[widx_next];
                        write_addr   <= write_addr + stride_q;
                        finish_write <= 1'b1;
                    end
                end
                S_FIN: cycles <= cnt;
                default: ;
            endcase
        end
    end

    // Buffer writes: host loads in READ, kernel ports in RUN (port 1 last so it wins).
    always_ff @(posedge clk) begin
        if (state == S_READ && read_ready) mem[rcnt[ADDR_WID-1:0]] <= read_data;
        if (state == S_RUN) begin
            if (k_ce0 && k_we0) mem[k_addr0] <= k_d0;
            if (k_ce1 && k_we1) mem[k_addr1] <= k_d1;
        end
    end

    // Kernel read ports: one-cycle latency, old data on same-cycle write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q0 <= '0;
            k_q1 <= '0;
        end else if (state == S_RUN) begin
            if (k_ce0 && !k_we0) k_q0 <= mem[k_addr0];
            if (k_ce1 && !k_we1) k_q1 <= mem[k_addr1];
        end
    end

`ifdef KERNEL_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

    logic [WD_W-1:0] wd_cnt;
    logic            error_q;

    assign timeout_hit = (state == S_RUN) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign error       = error_q;

    // Watchdog over RUN cycles; error stays set until the next accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt  <= '0;
            error_q <= 1'b0;
        end else begin
            if (state == S_RUN) wd_cnt <= wd_cnt + WD_ONE;
            else                wd_cnt <= '0;
            if (state == S_IDLE && start)   error_q <= 1'b0;
            else if (timeout_hit && !ap_done) error_q <= 1'b1;
        end
    end
`else
    // No watchdog: RUN waits for ap_done indefinitely and error never rises.
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_dma_shell.sv
// tb_kernel_dma_shell: randomized job-level bench for kernel_dma_shell.
// Define KERNEL_TIMEOUT_EN on both files to include the watchdog scenario.
`timescale 1ns/1ps
module tb_kernel_dma_shell;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int HW    = 32;
    localparam int DEPTH = 1 << AW;
    localparam int TO    = 100;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [HW-1:0] read_base = '0, write_base = '0, stride = '0, num_read = '0, num_write = '0;
    logic [AW-1:0] write_offset = '0;
    logic          read_ready = 1'b0, write_ready = 1'b0, ap_done = 1'b0;
    logic [DW-1:0] read_data = '0;
    logic          read_enable, write_enable, finish_read, finish_write, done, busy, error, ap_start;
    logic [HW-1:0] read_addr, read_size_output, write_addr, write_size, cycles;
    logic [DW-1:0] write_data, k_q0, k_q1;
    logic [AW-1:0] k_addr0 = '0, k_addr1 = '0;
    logic          k_ce0 = 1'b0, k_ce1 = 1'b0, k_we0 = 1'b0, k_we1 = 1'b0;
    logic [DW-1:0] k_d0 = '0, k_d1 = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int m_busy = 0, m_done = 0, m_aps = 0, m_fr = 0, m_fw = 0;

    // Reference model: buffer contents and expected host write stream.
    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] src [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [HW-1:0] exp_a [$];

    kernel_dma_shell #(.DATA_WID(DW), .ADDR_WID(AW), .HOST_AW(HW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .read_base(read_base), .write_base(write_base),
        .stride(stride), .num_read(num_read), .num_write(num_write), .write_offset(write_offset),
        .read_ready(read_ready), .read_data(read_data), .write_ready(write_ready),
        .read_enable(read_enable), .read_addr(read_addr), .read_size_output(read_size_output),
        .finish_read(finish_read), .write_enable(write_enable), .write_addr(write_addr),
        .write_size(write_size), .write_data(write_data), .finish_write(finish_write),
        .done(done), .busy(busy), .error(error), .cycles(cycles), .ap_start(ap_start),
        .ap_done(ap_done), .k_addr0(k_addr0), .k_addr1(k_addr1), .k_ce0(k_ce0), .k_ce1(k_ce1),
        .k_we0(k_we0), .k_we1(k_we1), .k_d0(k_d0), .k_d1(k_d1), .k_q0(k_q0), .k_q1(k_q1)
    );

    // Clock and global time limit.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Event counters for strobes, sampled away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            if (busy)         m_busy++;
            if (done)         m_done++;
            if (ap_start)     m_aps++;
            if (finish_read)  m_fr++;
            if (finish_write) m_fw++;
        end
    end

    // Kernel behaviour model; entered on the negedge where ap_start is seen.
    task automatic kernel(input int mode, input int n, output int kc);
        logic [DW-1:0] old6;
        kc = 0; ap_done = 1'b0; k_ce0 = 1'b0; k_ce1 = 1'b0; k_we0 = 1'b0; k_we1 = 1'b0;
        @(negedge clk); kc++;
        if (mode == 1) begin
            for (int a = 0; a + 1 < n && a < 16; a += 2) begin
                k_ce0 = 1'b1; k_we0 = 1'b0; k_addr0 = AW'(a);
                k_ce1 = 1'b1; k_we1 = 1'b0; k_addr1 = AW'(a + 1);
                @(negedge clk); kc++;
                n_checks++;
                if (k_q0 !== mdl[a] || k_q1 !== mdl[a+1])
                    $display("FAIL kernel_read a=%0d: got %h/%h want %h/%h", a, k_q0, k_q1, mdl[a], mdl[a+1]);
                else n_pass++;
                k_we0 = 1'b1; k_d0 = k_q0 << 1;
                k_we1 = 1'b1; k_d1 = k_q1 << 1;
                mdl[a] = mdl[a] * 2; mdl[a+1] = mdl[a+1] * 2;
                @(negedge clk); kc++;
            end
        end else if (mode == 2) begin
            k_ce0 = 1'b1; k_we0 = 1'b1; k_addr0 = AW'(5); k_d0 = 32'd7;
            k_ce1 = 1'b1; k_we1 = 1'b1; k_addr1 = AW'(5); k_d1 = 32'd9;
            mdl[5] = 32'd9;
            @(negedge clk); kc++;
            old6 = mdl[6];
            k_we0 = 1'b0; k_addr0 = AW'(6);
            k_we1 = 1'b1; k_addr1 = AW'(6); k_d1 = 32'h5a5a_0006;
            mdl[6] = 32'h5a5a_0006;
            @(negedge clk); kc++;
            n_checks++;
            if (k_q0 !== old6) $display("FAIL read_during_write: got %h want %h", k_q0, old6);
            else n_pass++;
            k_we0 = 1'b0; k_addr0 = AW'(5);
            k_we1 = 1'b0; k_addr1 = AW'(6);
            @(negedge clk); kc++;
            n_checks++;
            if (k_q0 !== 32'd9) $display("FAIL port_collision: got %h want 9", k_q0);
            else n_pass++;
            n_checks++;
            if (k_q1 !== mdl[6]) $display("FAIL write_then_read: got %h want %h", k_q1, mdl[6]);
            else n_pass++;
        end
        k_ce0 = 1'b0; k_ce1 = 1'b0; k_we0 = 1'b0; k_we1 = 1'b0;
        if (mode != 3) begin
            ap_done = 1'b1;
            @(negedge clk); kc++;
            ap_done = 1'b0;
        end
    endtask

    // One complete job: host driver, kernel model and end-of-job checks.
    task automatic run_job(input logic [HW-1:0] rb, input logic [HW-1:0] wb, input logic [HW-1:0] st,
                           input logic [HW-1:0] nr, input logic [HW-1:0] nw, input logic [AW-1:0] wo,
                           input bit stall, input int mode, input bit rnd_data);
        int rlen, wlen, rd_i, cyc, aps_cyc, kc, b0, d0, a0, fr0, fw0, exp_fr, exp_fw;
        bit got_done;
        logic exp_err;
        rlen = (nr > HW'(DEPTH)) ? DEPTH : int'(nr);
        wlen = (nw > HW'(DEPTH)) ? DEPTH : int'(nw);
        for (int i = 0; i < rlen; i++) begin
            src[i] = rnd_data ? DW'($urandom) : DW'(i + 1);
            mdl[i] = src[i];
        end
        exp_q.delete(); exp_a.delete();
        exp_err = (mode == 3);
        exp_fr  = (rlen > 0) ? rlen - 1 : 0;
        exp_fw  = (mode == 3 || wlen == 0) ? 0 : wlen - 1;
        b0 = m_busy; d0 = m_done; a0 = m_aps; fr0 = m_fr; fw0 = m_fw;
        read_base = rb; write_base = wb; stride = st; num_read = nr; num_write = nw; write_offset = wo;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1; rd_i = 0; got_done = 1'b0; aps_cyc = -1;
        while (!got_done && cyc < 4000) begin
            if (done) got_done = 1'b1;
            if (read_enable) begin
                n_checks++;
                if (rd_i >= rlen) $display("FAIL read_extra: word %0d of %0d", rd_i, rlen);
                else if (read_addr !== rb + HW'(rd_i) * st || read_size_output !== st)
                    $display("FAIL read_addr: got %h want %h", read_addr, rb + HW'(rd_i) * st);
                else n_pass++;
                read_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (rd_i < rlen) read_data = src[rd_i];
                if (read_ready) rd_i++;
            end else begin
                read_ready = 1'b0;
                read_data  = DW'($urandom);
            end
            if (write_enable) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL write_extra: addr %h data %h", write_addr, write_data);
                else if (write_addr !== exp_a[0] || write_data !== exp_q[0] || write_size !== st)
                    $display("FAIL write_word: got %h@%h want %h@%h", write_data, write_addr, exp_q[0], exp_a[0]);
                else n_pass++;
                write_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (write_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    void'(exp_a.pop_front());
                end
            end else begin
                write_ready = 1'b0;
            end
            if (ap_start) begin
                aps_cyc = cyc; start = 1'b0; read_ready = 1'b0; write_ready = 1'b0;
                kernel(mode, rlen, kc);
                cyc += kc;
                if (mode != 3)
                    for (int j = 0; j < wlen; j++) begin
                        exp_q.push_back(mdl[(int'(wo) + j) % DEPTH]);
                        exp_a.push_back(wb + HW'(j) * st);
                    end
            end else if (!got_done) begin
                ap_done = stall && (read_enable || write_enable) && ($urandom_range(0, 3) == 0);
                start   = stall && busy && ($urandom_range(0, 7) == 0);
                if (start) begin
                    read_base = $urandom; write_base = $urandom; stride = $urandom;
                    num_read = $urandom_range(1, 5); num_write = $urandom_range(1, 5);
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0; ap_done = 1'b0; read_ready = 1'b0; write_ready = 1'b0;
        n_checks++;
        if (!got_done) $display("FAIL job_timeout: no done within %0d cycles", cyc); else n_pass++;
        n_checks++;
        if (rd_i != rlen) $display("FAIL read_count: got %0d want %0d", rd_i, rlen); else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL write_count: %0d words left", exp_q.size()); else n_pass++;
        if (nr == 0) begin
            n_checks++;
            if (aps_cyc != 1) $display("FAIL ap_start_immediate: got cycle %0d want 1", aps_cyc); else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (cycles !== HW'(m_busy - b0)) $display("FAIL cycles: got %0d want %0d", cycles, m_busy - b0); else n_pass++;
        n_checks++;
        if (m_done - d0 != 1 || m_aps - a0 != 1)
            $display("FAIL pulse_count: done %0d ap_start %0d want 1/1", m_done - d0, m_aps - a0);
        else n_pass++;
        n_checks++;
        if (m_fr - fr0 != exp_fr || m_fw - fw0 != exp_fw)
            $display("FAIL finish_count: got %0d/%0d want %0d/%0d", m_fr - fr0, m_fw - fw0, exp_fr, exp_fw);
        else n_pass++;
        n_checks++;
        if (error !== exp_err || busy !== 1'b0) $display("FAIL end_flags: error %b busy %b want %b/0", error, busy, exp_err);
        else n_pass++;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({read_enable, write_enable, busy, done, error, ap_start, finish_read, finish_write} !== 8'h00)
            $display("FAIL reset_strobes: got %b want 0", {read_enable, write_enable, busy, done, error, ap_start, finish_read, finish_write});
        else n_pass++;
        n_checks++;
        if (read_addr !== '0 || write_addr !== '0 || cycles !== '0 || read_size_output !== '0 || write_size !== '0)
            $display("FAIL reset_host: got %h %h %h want 0", read_addr, write_addr, cycles);
        else n_pass++;
        n_checks++;
        if (k_q0 !== '0 || k_q1 !== '0 || write_data !== '0)
            $display("FAIL reset_data: got %h %h %h want 0", k_q0, k_q1, write_data);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run_job(32'h1000, 32'h2000, 32'd4, 32'd16, 32'd16, '0, 1'b0, 1, 1'b0);
    endtask

    task automatic test_stalls;
        run_job(32'h1000, 32'h2000, 32'd4, 32'd16, 32'd16, '0, 1'b1, 1, 1'b0);
        run_job(32'h8000, 32'h9000, 32'd8, 32'd16, 32'd12, AW'(2), 1'b1, 1, 1'b1);
    endtask

    task automatic test_clamp;
        run_job(32'h0100, 32'h0400, 32'd4, 32'd40, 32'd40, AW'(3), 1'b1, 0, 1'b1);
    endtask

    task automatic test_zero_offset;
        run_job(32'h0, 32'h5000, 32'd4, 32'd0, 32'd4, AW'(DEPTH - 2), 1'b0, 0, 1'b0);
    endtask

    task automatic test_collision;
        run_job(32'h0600, 32'h0700, 32'd4, 32'd8, 32'd8, AW'(0), 1'b0, 2, 1'b1);
    endtask

    task automatic test_reset_restart;
        int k, d0, guard;
        read_base = 32'h3000; write_base = 32'h4000; stride = 32'd8;
        num_read = 32'd16; num_write = 32'd4; write_offset = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; k = 0; guard = 0;
        while (k < 3 && guard < 50) begin
            if (read_enable) begin
                read_ready = 1'b1; read_data = DW'($urandom); mdl[k] = read_data; k++;
            end
            @(negedge clk);
            guard++;
        end
        d0 = m_done;
        read_ready = 1'b1; read_data = DW'($urandom);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({read_enable, busy, finish_read, done, ap_start} !== 5'b0 || read_addr !== '0 || cycles !== '0)
            $display("FAIL reset_midjob: strobes %b addr %h cycles %h want 0", {read_enable, busy, finish_read, done, ap_start}, read_addr, cycles);
        else n_pass++;
        read_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (m_done != d0 || busy !== 1'b0) $display("FAIL aborted_done: got %0d done pulses busy %b want 0", m_done - d0, busy);
        else n_pass++;
        run_job(32'h3000, 32'h4000, 32'd8, 32'd16, 32'd16, '0, 1'b1, 1, 1'b1);
        run_job(32'h3100, 32'h4100, 32'd4, 32'd6, 32'd5, AW'(1), 1'b1, 0, 1'b1);
    endtask

`ifdef KERNEL_TIMEOUT_EN
    task automatic test_watchdog;
        run_job(32'h0a00, 32'h0b00, 32'd4, 32'd4, 32'd4, '0, 1'b0, 3, 1'b1);
        run_job(32'h0a00, 32'h0b00, 32'd4, 32'd4, 32'd4, '0, 1'b0, 0, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_clamp();
        test_zero_offset();
        test_collision();
        test_reset_restart();
`ifdef KERNEL_TIMEOUT_EN
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
